// File: rtl/m72_pkg.sv
// Shared definitions for the M72 memory subsystem.
//   arb_state_t : state encoding of the SDRAM port arbiter
//   SDR_ADDR_W  : SDRAM word address width (sdr_addr[24:1])
//   SDR_DATA_W  : SDRAM data width
package m72_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  localparam int SDR_ADDR_W = 24;
  localparam int SDR_DATA_W = 16;

endpackage

// File: rtl/sdram_port_arbiter_chk.sv
// Protocol checker for sdram_port_arbiter (simulation-only properties).
// Ports (all inputs):
//   CLK_32M, reset_n          clock and asynchronous active-low reset
//   r0_req/r0_ack, r1_req/r1_ack  requester toggle pairs
//   sdr_req/sdr_ack           SDRAM-side toggle pair
//   busy                      arbiter transaction-outstanding flag
module sdram_port_arbiter_chk (
  input logic CLK_32M,
  input logic reset_n,
  input logic r0_req,
  input logic r0_ack,
  input logic r1_req,
  input logic r1_ack,
  input logic sdr_req,
  input logic sdr_ack,
  input logic busy
);

  // A pending requester may only toggle again once its ack has toggled.
  a_r0_no_retoggle: assert property (@(posedge CLK_32M) disable iff (!reset_n)
    (r0_req != r0_ack) |=> ((r0_req == $past(r0_req)) || (r0_ack != $past(r0_ack))));

  a_r1_no_retoggle: assert property (@(posedge CLK_32M) disable iff (!reset_n)
    (r1_req != r1_ack) |=> ((r1_req == $past(r1_req)) || (r1_ack != $past(r1_ack))));

  // With nothing outstanding the SDRAM toggle pair must be balanced.
  a_idle_balanced: assert property (@(posedge CLK_32M) disable iff (!reset_n)
    !busy |-> (sdr_req == sdr_ack));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter for one toggle-handshake SDRAM port.
// One transaction is in flight at a time; the winner's request is latched
// at grant and replayed upstream, and its ack toggle is returned on completion.
// Ports:
//   CLK_32M, reset_n                 clock, asynchronous active-low reset
//   rN_addr/rN_din/rN_wr_sel/rN_req  requester N request (wr_sel 00 = read)
//   rN_ack/rN_dout                   requester N ack toggle and read data
//   sdr_addr/sdr_din/sdr_wr_sel/sdr_req  SDRAM request side
//   sdr_ack/sdr_dout                 SDRAM ack toggle and read data
//   owner                            requester of current/last transaction
//   busy                             transaction outstanding
module sdram_port_arbiter
  import m72_pkg::*;
#(
  parameter int ADDR_W      = SDR_ADDR_W,
  parameter int DATA_W      = SDR_DATA_W,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              CLK_32M,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_din,
  input  logic [1:0]        r0_wr_sel,
  input  logic              r0_req,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_dout,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_din,
  input  logic [1:0]        r1_wr_sel,
  input  logic              r1_req,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_dout,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [DATA_W-1:0] sdr_din,
  output logic [1:0]        sdr_wr_sel,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [DATA_W-1:0] sdr_dout,
  output logic              owner,
  output logic              busy
);

  arb_state_t state_r;
  logic       pend0_s;
  logic       pend1_s;
  logic       win_s;
  logic       done_s;

  // Two-way winner select; 'last' is the previous owner, which doubles as
  // the round-robin pointer.
  function automatic logic pick_winner(input logic p0, input logic p1, input logic last);
    logic w;
    if (p0 && p1) begin
      if (ROUND_ROBIN != 0) begin
        w = ~last;
      end else begin
        w = 1'b0;
      end
    end else if (p1) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

  // Pending flags, winner and completion detect.
  always_comb begin
    pend0_s = r0_req ^ r0_ack;
    pend1_s = r1_req ^ r1_ack;
    win_s   = pick_winner(pend0_s, pend1_s, owner);
    done_s  = (sdr_ack == sdr_req);
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ARB_IDLE;
      r0_ack     <= 1'b0;
      r0_dout    <= '0;
      r1_ack     <= 1'b0;
      r1_dout    <= '0;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      sdr_wr_sel <= 2'b00;
      sdr_req    <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pend0_s || pend1_s) begin
            if (win_s) begin
              sdr_addr   <= r1_addr;
              sdr_din    <= r1_din;
              sdr_wr_sel <= r1_wr_sel;
            end else begin
              sdr_addr   <= r0_addr;
              sdr_din    <= r0_din;
              sdr_wr_sel <= r0_wr_sel;
            end
            sdr_req <= ~sdr_req;
            owner   <= win_s;
            busy    <= 1'b1;
            state_r <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (done_s) begin
            // sdr_wr_sel still holds the granted request's enables.
            if (owner) begin
              r1_ack <= r1_req;
              if (sdr_wr_sel == 2'b00) begin
                r1_dout <= sdr_dout;
              end
            end else begin
              r0_ack <= r0_req;
              if (sdr_wr_sel == 2'b00) begin
                r0_dout <= sdr_dout;
              end
            end
            busy    <= 1'b0;
            state_r <= ARB_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  sdram_port_arbiter_chk u_chk (
    .CLK_32M (CLK_32M),
    .reset_n (reset_n),
    .r0_req  (r0_req),
    .r0_ack  (r0_ack),
    .r1_req  (r1_req),
    .r1_ack  (r1_ack),
    .sdr_req (sdr_req),
    .sdr_ack (sdr_ack),
    .busy    (busy)
  );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: instance A (round robin) with a
// grant/completion scoreboard, instance B (fixed priority) for starvation.
module tb_sdram_port_arbiter;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int LAT = 3;

  logic CLK_32M = 1'b0;
  always #5 CLK_32M = ~CLK_32M;
  logic reset_n;

  // instance A signals
  logic [AW-1:0] a_r0_addr, a_r1_addr, a_sdr_addr;
  logic [DW-1:0] a_r0_din, a_r1_din, a_sdr_din, a_r0_dout, a_r1_dout, a_sdr_dout, a_rdata;
  logic [1:0]    a_r0_wr_sel, a_r1_wr_sel, a_sdr_wr_sel;
  logic          a_r0_req, a_r1_req, a_r0_ack, a_r1_ack, a_sdr_req, a_sdr_ack, a_owner, a_busy;
  int            a_cnt;

  // instance B signals
  logic [AW-1:0] b_r0_addr, b_r1_addr, b_sdr_addr;
  logic [DW-1:0] b_r0_din, b_r1_din, b_sdr_din, b_r0_dout, b_r1_dout, b_sdr_dout, b_rdata;
  logic [1:0]    b_r0_wr_sel, b_r1_wr_sel, b_sdr_wr_sel;
  logic          b_r0_req, b_r1_req, b_r0_ack, b_r1_ack, b_sdr_req, b_sdr_ack, b_owner, b_busy;
  int            b_cnt;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1)) dut_a (
    .CLK_32M(CLK_32M), .reset_n(reset_n),
    .r0_addr(a_r0_addr), .r0_din(a_r0_din), .r0_wr_sel(a_r0_wr_sel), .r0_req(a_r0_req),
    .r0_ack(a_r0_ack), .r0_dout(a_r0_dout),
    .r1_addr(a_r1_addr), .r1_din(a_r1_din), .r1_wr_sel(a_r1_wr_sel), .r1_req(a_r1_req),
    .r1_ack(a_r1_ack), .r1_dout(a_r1_dout),
    .sdr_addr(a_sdr_addr), .sdr_din(a_sdr_din), .sdr_wr_sel(a_sdr_wr_sel), .sdr_req(a_sdr_req),
    .sdr_ack(a_sdr_ack), .sdr_dout(a_sdr_dout), .owner(a_owner), .busy(a_busy)
  );

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0)) dut_b (
    .CLK_32M(CLK_32M), .reset_n(reset_n),
    .r0_addr(b_r0_addr), .r0_din(b_r0_din), .r0_wr_sel(b_r0_wr_sel), .r0_req(b_r0_req),
    .r0_ack(b_r0_ack), .r0_dout(b_r0_dout),
    .r1_addr(b_r1_addr), .r1_din(b_r1_din), .r1_wr_sel(b_r1_wr_sel), .r1_req(b_r1_req),
    .r1_ack(b_r1_ack), .r1_dout(b_r1_dout),
    .sdr_addr(b_sdr_addr), .sdr_din(b_sdr_din), .sdr_wr_sel(b_sdr_wr_sel), .sdr_req(b_sdr_req),
    .sdr_ack(b_sdr_ack), .sdr_dout(b_sdr_dout), .owner(b_owner), .busy(b_busy)
  );

  // SDRAM models: ack LAT cycles after a new request, returning the data word set by the bench.
  always @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      a_sdr_ack <= 1'b0; a_cnt <= 0; a_sdr_dout <= 16'h0000;
    end else if (a_sdr_req != a_sdr_ack) begin
      if (a_cnt == LAT - 1) begin
        a_sdr_ack <= a_sdr_req; a_cnt <= 0; a_sdr_dout <= a_rdata;
      end else begin
        a_cnt <= a_cnt + 1;
      end
    end
  end

  always @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      b_sdr_ack <= 1'b0; b_cnt <= 0; b_sdr_dout <= 16'h0000;
    end else if (b_sdr_req != b_sdr_ack) begin
      if (b_cnt == LAT - 1) begin
        b_sdr_ack <= b_sdr_req; b_cnt <= 0; b_sdr_dout <= b_rdata;
      end else begin
        b_cnt <= b_cnt + 1;
      end
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: grants and completions expected in order for instance A.
  typedef struct packed {
    logic          own;
    logic [1:0]    ws;
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
  } grant_t;
  typedef struct packed {
    logic          port;
    logic [DW-1:0] dout;
  } cpl_t;

  grant_t exp_g[$];
  cpl_t   exp_c[$];
  logic   pa_req, pa_ack0, pa_ack1, pb_req;
  int     a_toggles   = 0;
  int     b_own1_cnt  = 0;

  always @(negedge CLK_32M) begin
    grant_t g;
    cpl_t   c;
    if (!reset_n) begin
      pa_req <= 1'b0; pa_ack0 <= 1'b0; pa_ack1 <= 1'b0; pb_req <= 1'b0;
    end else begin
      if (a_sdr_req !== pa_req) begin
        a_toggles++;
        if (exp_g.size() == 0) begin
          chk("grant_unexpected", 64'(1), 64'(0));
        end else begin
          g = exp_g.pop_front();
          chk("grant", 64'({a_owner, a_sdr_wr_sel, a_sdr_din, a_sdr_addr}), 64'(g));
        end
      end
      if ((a_r0_ack !== pa_ack0) || (a_r1_ack !== pa_ack1)) begin
        if (exp_c.size() == 0) begin
          chk("cpl_unexpected", 64'(1), 64'(0));
        end else begin
          c = exp_c.pop_front();
          if (a_r1_ack !== pa_ack1) chk("cpl_r1", 64'({1'b1, a_r1_dout}), 64'(c));
          else                      chk("cpl_r0", 64'({1'b0, a_r0_dout}), 64'(c));
        end
      end
      if ((b_sdr_req !== pb_req) && (b_owner === 1'b1)) b_own1_cnt++;
      pa_req <= a_sdr_req; pa_ack0 <= a_r0_ack; pa_ack1 <= a_r1_ack; pb_req <= b_sdr_req;
    end
  end

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic a_go0(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [1:0] ws);
    a_r0_addr = ad; a_r0_din = d; a_r0_wr_sel = ws; a_r0_req = ~a_r0_req;
  endtask

  task automatic a_go1(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [1:0] ws);
    a_r1_addr = ad; a_r1_din = d; a_r1_wr_sel = ws; a_r1_req = ~a_r1_req;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!a_busy && (exp_c.size() == 0) && (exp_g.size() == 0) &&
          (a_r0_ack == a_r0_req) && (a_r1_ack == a_r1_req)) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  initial begin
    int   t0;
    int   n0;
    logic ok;
    reset_n = 1'b1;
    {a_r0_addr, a_r1_addr, a_r0_din, a_r1_din, a_r0_wr_sel, a_r1_wr_sel, a_r0_req, a_r1_req} = '0;
    {b_r0_addr, b_r1_addr, b_r0_din, b_r1_din, b_r0_wr_sel, b_r1_wr_sel, b_r0_req, b_r1_req} = '0;
    a_rdata = 16'h0000;
    b_rdata = 16'h0B0B;
    #1 reset_n = 1'b0;
    #2;
    // reset state
    chk("rst_sdr_req", 64'(a_sdr_req), 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));
    chk("rst_owner", 64'(a_owner), 64'(0));
    chk("rst_acks", 64'({a_r0_ack, a_r1_ack}), 64'(0));
    chk("rst_sdr_addr", 64'(a_sdr_addr), 64'(0));
    chk("rst_douts", 64'({a_r0_dout, a_r1_dout}), 64'(0));
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 1: single r0 read
    a_rdata = 16'hBEEF;
    exp_g.push_back('{1'b0, 2'b00, 16'h0000, 24'h012345});
    exp_c.push_back('{1'b0, 16'hBEEF});
    a_go0(24'h012345, 16'h0000, 2'b00);
    tick();
    chk("t1_req_latency", 64'(a_sdr_req), 64'(1));
    chk("t1_busy", 64'(a_busy), 64'(1));
    wait_idle("t1_done");
    chk("t1_r0_dout", 64'(a_r0_dout), 64'(16'hBEEF));
    chk("t1_r0_ack", 64'(a_r0_ack), 64'(1));

    // 2: r1 write leaves r1_dout unchanged
    a_rdata = 16'hDEAD;
    exp_g.push_back('{1'b1, 2'b10, 16'hA55A, 24'h000ABC});
    exp_c.push_back('{1'b1, 16'h0000});
    a_go1(24'h000ABC, 16'hA55A, 2'b10);
    wait_idle("t2_done");
    chk("t2_r1_dout", 64'(a_r1_dout), 64'(0));
    chk("t2_owner", 64'(a_owner), 64'(1));

    // bring last owner back to 0
    a_rdata = 16'h1111;
    exp_g.push_back('{1'b0, 2'b00, 16'h0000, 24'h000100});
    exp_c.push_back('{1'b0, 16'h1111});
    a_go0(24'h000100, 16'h0000, 2'b00);
    wait_idle("t3pre_done");

    // 3: simultaneous requests, RR with last owner 0 -> r1 first
    a_rdata = 16'h7777;
    t0 = a_toggles;
    exp_g.push_back('{1'b1, 2'b00, 16'h0000, 24'h000200});
    exp_g.push_back('{1'b0, 2'b00, 16'h0000, 24'h000300});
    exp_c.push_back('{1'b1, 16'h7777});
    exp_c.push_back('{1'b0, 16'h7777});
    a_go1(24'h000200, 16'h0000, 2'b00);
    a_go0(24'h000300, 16'h0000, 2'b00);
    tick();
    chk("t3_first_owner", 64'(a_owner), 64'(1));
    wait_idle("t3_done");
    chk("t3_toggles", 64'(a_toggles - t0), 64'(2));

    // 6: address change after grant does not disturb the transaction
    a_rdata = 16'h6666;
    exp_g.push_back('{1'b0, 2'b00, 16'h0000, 24'h0A0A0A});
    exp_c.push_back('{1'b0, 16'h6666});
    a_go0(24'h0A0A0A, 16'h0000, 2'b00);
    tick();
    a_r0_addr = 24'hFFFFFF;
    tick();
    chk("t6_addr_held", 64'(a_sdr_addr), 64'(24'h0A0A0A));
    wait_idle("t6_done");

    // 5: reset during WAIT
    a_rdata = 16'h5555;
    exp_g.push_back('{1'b0, 2'b00, 16'h0000, 24'h000777});
    a_go0(24'h000777, 16'h0000, 2'b00);
    tick(); tick();
    chk("t5_in_wait", 64'(a_busy), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_req", 64'(a_sdr_req), 64'(0));
    chk("t5_rst_busy", 64'(a_busy), 64'(0));
    chk("t5_rst_ack", 64'({a_r0_ack, a_r1_ack}), 64'(0));
    chk("t5_rst_dout", 64'(a_r0_dout), 64'(0));
    chk("t5_rst_addr", 64'(a_sdr_addr), 64'(0));
    chk("t5_rst_owner", 64'(a_owner), 64'(0));
    a_r0_req = 1'b0; a_r1_req = 1'b0; b_r0_req = 1'b0; b_r1_req = 1'b0;
    exp_c.delete();
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();
    a_rdata = 16'h4242;
    exp_g.push_back('{1'b0, 2'b00, 16'h0000, 24'h000055});
    exp_c.push_back('{1'b0, 16'h4242});
    a_go0(24'h000055, 16'h0000, 2'b00);
    wait_idle("t5_after_done");
    chk("t5_after_dout", 64'(a_r0_dout), 64'(16'h4242));

    // 4: fixed priority -> r0 wins, back-to-back r0 keeps r1 waiting
    b_r0_addr = 24'h000010; b_r1_addr = 24'h000020;
    b_r0_req = ~b_r0_req; b_r1_req = ~b_r1_req;
    tick();
    chk("t4_first_owner", 64'(b_owner), 64'(0));
    chk("t4_first_addr", 64'(b_sdr_addr), 64'(24'h000010));
    n0 = 0;
    for (int i = 0; i < 100; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (b_r0_ack == b_r0_req) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      if (!ok) break;
      n0++;
      if (i < 99) b_r0_req = ~b_r0_req;
    end
    chk("t4_r0_count", 64'(n0), 64'(100));
    chk("t4_r1_waiting", 64'(b_r1_ack), 64'(0));
    chk("t4_no_r1_grant", 64'(b_own1_cnt), 64'(0));
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (b_r1_ack == b_r1_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("t4_r1_served", 64'(ok), 64'(1));
    chk("t4_r1_dout", 64'(b_r1_dout), 64'(16'h0B0B));
    chk("t4_r1_grants", 64'(b_own1_cnt), 64'(1));

    tick();
    chk("sb_empty", 64'(exp_g.size() + exp_c.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
